// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and constants for the reset sequencer
//
// Purpose: state encoding, lock-loss counter width and the sequencing
//          counter width function used by reset_sequencer.
// Ports:   none (package).
package reset_seq_pkg;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      STABLE  = 2'd1,
      RELEASE = 2'd2,
      RUN     = 2'd3
   } seq_state_e;

   localparam int LOCK_CNT_W = 8;

   // Wide enough for the larger of the lock-stable window and the full
   // release ramp, plus one bit of headroom for the increment on exit.
   function automatic int seq_cnt_width(input int lock_stable, input int n_dom, input int stage);
      int m;
      m = (lock_stable > n_dom * stage) ? lock_stable : n_dom * stage;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - single-bit multi-flop input synchroniser
//
// Purpose: brings an asynchronous level into the clk domain.
// Ports:   clk  - sampling clock
//          rst  - synchronous active-high reset, clears every stage to 0
//          d_i  - asynchronous input
//          q_o  - synchronised output, STAGES cycles behind d_i
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged multi-domain reset release after PLL lock
//
// Purpose: synchronises the board button and PLL lock, waits for a stable
//          lock window, then releases N_DOMAINS active-low resets in index
//          order at fixed spacing. Any loss of "good" re-asserts all domains.
//          Optional button debounce is compiled in with RESET_SEQ_DEBOUNCE_EN.
// Ports:   clk             - system clock
//          rst             - synchronous active-high reset
//          btn_rst_n_i     - asynchronous board reset button, active low
//          pll_locked_i    - asynchronous PLL lock
//          sw_rst_req_i    - synchronous one-cycle software reset request
//          rst_n_o         - per-domain active-low resets, bit 0 released first
//          all_released_o  - every domain released
//          state_o         - current sequencer state
//          lock_lost_cnt_o - saturating count of lock falling edges
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int N_DOMAINS          = 3,
   parameter int STAGE_CYCLES       = 16,
   parameter int LOCK_STABLE_CYCLES = 256,
   parameter int SYNC_STAGES        = 2,
   parameter int DEBOUNCE_CYCLES    = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  btn_rst_n_i,
   input  logic                  pll_locked_i,
   input  logic                  sw_rst_req_i,
   output logic [N_DOMAINS-1:0]  rst_n_o,
   output logic                  all_released_o,
   output logic [1:0]            state_o,
   output logic [LOCK_CNT_W-1:0] lock_lost_cnt_o
);

   localparam int CNT_W = seq_cnt_width(LOCK_STABLE_CYCLES, N_DOMAINS, STAGE_CYCLES);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(N_DOMAINS * STAGE_CYCLES - 1);

   if (N_DOMAINS < 1 || N_DOMAINS > 8 || STAGE_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 ||
       SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
      $error("reset_sequencer: parameter out of range");
   end

   logic btn_sync;
   logic lock_s;
   logic btn_s;
   logic good;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_btn (
      .clk (clk),
      .rst (rst),
      .d_i (btn_rst_n_i),
      .q_o (btn_sync)
   );

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lock (
      .clk (clk),
      .rst (rst),
      .d_i (pll_locked_i),
      .q_o (lock_s)
   );

`ifdef RESET_SEQ_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            btn_db_q;
   logic [DB_W-1:0] db_cnt_q;

   // The debounced copy starts as "pressed" so the domains stay held until
   // the button has been seen released for a full window.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_db_q <= 1'b0;
         db_cnt_q <= '0;
      end else if (btn_sync == btn_db_q) begin
         db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
         btn_db_q <= btn_sync;
         db_cnt_q <= '0;
      end else begin
         db_cnt_q <= db_cnt_q + DB_W'(1);
      end
   end

   assign btn_s = btn_db_q;
`else
   assign btn_s = btn_sync;
`endif

   assign good = lock_s & btn_s & ~sw_rst_req_i;

   seq_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [N_DOMAINS-1:0]  rst_n_q, rst_n_d;
   logic                  all_rel_q;
   logic                  lock_prev_q;
   logic [LOCK_CNT_W-1:0] lock_lost_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rst_n_d = rst_n_q;
      // Not-good wins over every transition, including terminal counts.
      if (!good) begin
         state_d = HOLD;
         cnt_d   = '0;
         rst_n_d = '0;
      end else begin
         case (state_q)
            HOLD: begin
               state_d = STABLE;
               cnt_d   = '0;
               rst_n_d = '0;
            end
            STABLE: begin
               if (cnt_q == STABLE_LAST) begin
                  state_d = RELEASE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RELEASE: begin
               cnt_d = cnt_q + CNT_W'(1);
               for (int k = 0; k < N_DOMAINS; k++) begin
                  if (cnt_q == CNT_W'((k + 1) * STAGE_CYCLES - 1)) begin
                     rst_n_d[k] = 1'b1;
                  end
               end
               if (cnt_q == RELEASE_LAST) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end
            end
            RUN: begin
               rst_n_d = '1;
            end
            default: begin
               state_d = HOLD;
               cnt_d   = '0;
               rst_n_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HOLD;
         cnt_q       <= '0;
         rst_n_q     <= '0;
         all_rel_q   <= 1'b0;
         lock_prev_q <= 1'b0;
         lock_lost_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rst_n_q     <= rst_n_d;
         all_rel_q   <= &rst_n_d;
         lock_prev_q <= lock_s;
         if (lock_prev_q && !lock_s && (lock_lost_q != '1)) begin
            lock_lost_q <= lock_lost_q + LOCK_CNT_W'(1);
         end
      end
   end

   assign rst_n_o         = rst_n_q;
   assign all_released_o  = all_rel_q;
   assign state_o         = state_q;
   assign lock_lost_cnt_o = lock_lost_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn;
   logic       lock;
   logic       sw;
   logic [2:0] rst_n;
   logic       all_rel;
   logic [1:0] state;
   logic [7:0] lcnt;

   always #5 clk = ~clk;

   reset_sequencer #(
      .N_DOMAINS          (3),
      .STAGE_CYCLES       (4),
      .LOCK_STABLE_CYCLES (8),
      .SYNC_STAGES        (2),
      .DEBOUNCE_CYCLES    (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .btn_rst_n_i     (btn),
      .pll_locked_i    (lock),
      .sw_rst_req_i    (sw),
      .rst_n_o         (rst_n),
      .all_released_o  (all_rel),
      .state_o         (state),
      .lock_lost_cnt_o (lcnt)
   );

   typedef struct {
      int    cyc;
      int    rn;
      int    st;
      int    ar;
      int    lc;
      string nm;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected outputs keyed by absolute cycle; -1 marks a don't-care field.
   task automatic expect_at(input int off, input int rn, input int st, input int ar,
                            input int lc, input string nm);
      exp_t e;
      int   i;
      e.cyc = cyc + off;
      e.rn  = rn;
      e.st  = st;
      e.ar  = ar;
      e.lc  = lc;
      e.nm  = nm;
      i = 0;
      while (i < sb_q.size() && sb_q[i].cyc <= e.cyc) i++;
      sb_q.insert(i, e);
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic bit fld_ok(input int e, input int a);
      return (e < 0) || (e == a);
   endfunction

   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         mon_e = sb_q.pop_front();
         n_cmp++;
         if (mon_e.cyc != cyc || !fld_ok(mon_e.rn, int'(rst_n)) || !fld_ok(mon_e.st, int'(state)) ||
             !fld_ok(mon_e.ar, int'(all_rel)) || !fld_ok(mon_e.lc, int'(lcnt))) begin
            n_bad++;
            $display("FAIL %s cyc=%0d(exp %0d): got rst_n=%0d state=%0d all=%0d lcnt=%0d, expected rst_n=%0d state=%0d all=%0d lcnt=%0d",
                     mon_e.nm, cyc, mon_e.cyc, rst_n, state, all_rel, lcnt,
                     mon_e.rn, mon_e.st, mon_e.ar, mon_e.lc);
         end
      end
   end

   initial begin
      rst  = 1'b1;
      btn  = 1'b1;
      lock = 1'b0;
      sw   = 1'b0;
      @(negedge clk);
      expect_at(1, 0, 0, 0, 0, "reset_state");
      wait_n(2);
      rst = 1'b0;
      wait_n(7);
      lock = 1'b1;
`ifdef RESET_SEQ_DEBOUNCE_EN
      expect_at(11, 0, 0, 0, 0, "db_pu_hold_end");
      expect_at(12, 0, 1, 0, 0, "db_pu_stable");
      expect_at(20, 0, 2, 0, 0, "db_pu_release");
      expect_at(24, 1, 2, 0, 0, "db_pu_d0");
      expect_at(28, 3, 2, 0, 0, "db_pu_d1");
      expect_at(40, 7, 3, 1, 0, "db_pu_run");
      wait_n(45);
      btn = 1'b0;
      expect_at(13, 7, 3, 1, 0, "db_short_mid");
      expect_at(25, 7, 3, 1, 0, "db_short_after");
      wait_n(10);
      btn = 1'b1;
      wait_n(25);
      btn = 1'b0;
      expect_at(18, 7, 3, 1, 0, "db_long_pre");
      expect_at(19, 0, 0, 0, 0, "db_long_reset");
      wait_n(20);
      btn = 1'b1;
      wait_n(5);
`else
      // Power-up sequence, lock raised at cycle 10.
      expect_at(2,  0, 0, 0, 0, "pu_hold");
      expect_at(3,  0, 1, 0, 0, "pu_stable");
      expect_at(10, 0, 1, 0, 0, "pu_stable_end");
      expect_at(11, 0, 2, 0, 0, "pu_release");
      expect_at(14, 0, 2, 0, 0, "pu_pre_d0");
      expect_at(15, 1, 2, 0, 0, "pu_d0");
      expect_at(19, 3, 2, 0, 0, "pu_d1");
      expect_at(22, 3, 2, 0, 0, "pu_pre_d2");
      expect_at(23, 7, 3, 1, 0, "pu_d2");
      wait_n(30);
      // Lock loss in RUN.
      lock = 1'b0;
      expect_at(2, 7, 3, 1, 0, "run_pre_loss");
      expect_at(3, 0, 0, 0, 1, "run_loss");
      wait_n(5);
      lock = 1'b1;
      expect_at(3, 0, 1, 0, 1, "reseq_stable");
      wait_n(6);
      // One-cycle lock glitch during STABLE, then sw request at rst_n=011.
      lock = 1'b0;
      expect_at(2,  0, 1, 0, 1, "gl_pre");
      expect_at(3,  0, 0, 0, 2, "gl_hold");
      expect_at(4,  0, 1, 0, 2, "gl_restable");
      expect_at(11, 0, 1, 0, 2, "gl_stable_end");
      expect_at(12, 0, 2, 0, 2, "gl_release");
      expect_at(16, 1, 2, 0, 2, "gl_d0");
      expect_at(20, 3, 2, 0, 2, "gl_d1");
      expect_at(21, 3, 2, 0, 2, "sw_pre");
      expect_at(22, 0, 0, 0, 2, "sw_hold");
      expect_at(23, 0, 1, 0, 2, "sw_restable");
      expect_at(31, 0, 2, 0, 2, "sw_release");
      expect_at(35, 1, 2, 0, 2, "sw_d0");
      expect_at(43, 7, 3, 1, 2, "sw_run");
      wait_n(1);
      lock = 1'b1;
      wait_n(20);
      sw = 1'b1;
      wait_n(1);
      sw = 1'b0;
      wait_n(25);
      // 300 lock drops saturate the counter.
      for (int k = 1; k <= 300; k++) begin
         lock = 1'b0;
         if (k == 1)   expect_at(3, -1, -1, -1, 3,   "ll_first");
         if (k == 252) expect_at(3, -1, -1, -1, 254, "ll_254");
         if (k == 253) expect_at(3, -1, -1, -1, 255, "ll_255");
         if (k == 300) expect_at(3, -1, 0, 0, 255,   "ll_last");
         wait_n(2);
         lock = 1'b1;
         wait_n(2);
      end
      expect_at(1,  -1, -1, -1, 255, "ll_hold255");
      expect_at(12, 0, 2, 0, 255, "rst_pre_d0");
      expect_at(13, 1, 2, 0, 255, "rst_pre");
      wait_n(14);
      // rst in the middle of RELEASE clears everything on the next edge.
      rst = 1'b1;
      expect_at(1, 0, 0, 0, 0, "rst_mid");
      wait_n(1);
      rst = 1'b0;
      wait_n(3);
`endif
      for (int t = 0; t < 200 && sb_q.size() > 0; t++) @(negedge clk);
      if (sb_q.size() > 0) begin
         $display("FAIL scoreboard_timeout: %0d expectations left, required 0", sb_q.size());
         n_cmp += sb_q.size();
         n_bad += sb_q.size();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
